debug_module: RTL and testbench

Debug checker for the 8-bit accumulator microprocessor. It watches the program counter and accumulator buses of `top` and compares the accumulator, once per clock, against a per-address expected-value table. It flags and counts mismatches so a bench or on-chip debug logic can report pass/fail. It is purely observational: it never drives the processor.

---
 rtl/debug_module.sv | 81 ++++++++
 tb/tb_debug_module.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/debug_module.sv
// Observational checker: compares the accumulator against a per-PC expected table and counts failures.
// Define DEBUG_MODULE_DISPLAY_EN to print each failed compare and an end-of-simulation summary.
module debug_module #(
  parameter int INS_ADDR_WIDTH = 6,
  parameter int MEM_WIDTH      = 8,
  parameter int MEM_LEN        = 64
) (
  input  logic                      clk,
  input  logic                      nReset,
  input  logic [INS_ADDR_WIDTH-1:0] addr,
  input  logic [MEM_WIDTH-1:0]      accuValue,
  input  logic                      chk_en,
  input  logic                      exp_we,
  input  logic [INS_ADDR_WIDTH-1:0] exp_addr,
  input  logic [MEM_WIDTH-1:0]      exp_data,
  input  logic                      exp_clr,
  output logic                      mismatch,
  output logic [15:0]               err_count,
  output logic [15:0]               chk_count,
  output logic [INS_ADDR_WIDTH-1:0] first_err_addr,
  output logic [MEM_WIDTH-1:0]      first_err_data,
  output logic                      fail
);

  logic [MEM_WIDTH-1:0] exp_mem [MEM_LEN];
  logic [MEM_LEN-1:0]   exp_valid;

  logic addr_ok;
  logic wr_ok;
  logic chk_hit;
  logic chk_fail;

  assign addr_ok  = 32'(addr) < 32'(MEM_LEN);
  assign wr_ok    = 32'(exp_addr) < 32'(MEM_LEN);
  assign chk_hit  = chk_en && addr_ok && exp_valid[addr];
  assign chk_fail = chk_hit && (accuValue != exp_mem[addr]);

  // NOTE: the data array has no reset; only the valid bits need a defined state,
  // which keeps the array mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (exp_we && wr_ok) exp_mem[exp_addr] <= exp_data;
  end

  // NOTE: non-blocking updates mean a same-cycle write is invisible to this
  // cycle's compare, which therefore sees the old data and old valid bit.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      exp_valid      <= '0;
      mismatch       <= 1'b0;
      err_count      <= '0;
      chk_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      fail           <= 1'b0;
    end else begin
      if (exp_clr) exp_valid <= '0;
      // Placed after the clear so a simultaneous write keeps its entry valid.
      if (exp_we && wr_ok) exp_valid[exp_addr] <= 1'b1;

      mismatch <= chk_fail;
      if (chk_hit && chk_count != 16'hFFFF) chk_count <= chk_count + 16'd1;
      if (chk_fail && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      if (chk_fail && !fail) begin
        first_err_addr <= addr;
        first_err_data <= accuValue;
        fail           <= 1'b1;
      end
    end
  end

`ifdef DEBUG_MODULE_DISPLAY_EN
  always @(posedge clk) begin
    if (nReset && chk_fail)
      $display("%0t debug_module: compare failed addr=%0d expected=%0d accu=%0d",
               $time, addr, exp_mem[addr], accuValue);
  end

  final $display("debug_module summary: chk_count=%0d err_count=%0d", chk_count, err_count);
`endif

endmodule

// File: tb/tb_debug_module.sv
// Directed bench for debug_module: table-driven vectors plus hand-written multi-cycle sequences.
module tb_debug_module;

  logic       clk = 1'b0;
  logic       nReset;
  logic [5:0] addr;
  logic [7:0] accuValue;
  logic       chk_en;
  logic       exp_we;
  logic [5:0] exp_addr;
  logic [7:0] exp_data;
  logic       exp_clr;

  logic        mismatch,   s_mismatch;
  logic [15:0] err_count,  s_err_count;
  logic [15:0] chk_count,  s_chk_count;
  logic [5:0]  first_err_addr, s_first_err_addr;
  logic [7:0]  first_err_data, s_first_err_data;
  logic        fail,       s_fail;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  debug_module dut (
    .clk(clk), .nReset(nReset), .addr(addr), .accuValue(accuValue), .chk_en(chk_en),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data), .exp_clr(exp_clr),
    .mismatch(mismatch), .err_count(err_count), .chk_count(chk_count),
    .first_err_addr(first_err_addr), .first_err_data(first_err_data), .fail(fail)
  );

  // Shorter table so the addr >= MEM_LEN boundary is reachable.
  debug_module #(.INS_ADDR_WIDTH(6), .MEM_WIDTH(8), .MEM_LEN(40)) dut_small (
    .clk(clk), .nReset(nReset), .addr(addr), .accuValue(accuValue), .chk_en(chk_en),
    .exp_we(exp_we), .exp_addr(exp_addr), .exp_data(exp_data), .exp_clr(exp_clr),
    .mismatch(s_mismatch), .err_count(s_err_count), .chk_count(s_chk_count),
    .first_err_addr(s_first_err_addr), .first_err_data(s_first_err_data), .fail(s_fail)
  );

  typedef struct {
    logic        we;
    logic [5:0]  ea;
    logic [7:0]  ed;
    logic        clr;
    logic        en;
    logic [5:0]  pc;
    logic [7:0]  acc;
    logic        mm;
    logic [15:0] err;
    logic [15:0] chk;
    logic        fl;
    logic [5:0]  fea;
    logic [7:0]  fed;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic mm, input logic [15:0] err,
                           input logic [15:0] chk, input logic fl,
                           input logic [5:0] fea, input logic [7:0] fed);
    check({tag, " mismatch"}, 32'(mismatch), 32'(mm));
    check({tag, " err_count"}, 32'(err_count), 32'(err));
    check({tag, " chk_count"}, 32'(chk_count), 32'(chk));
    check({tag, " fail"}, 32'(fail), 32'(fl));
    check({tag, " first_err_addr"}, 32'(first_err_addr), 32'(fea));
    check({tag, " first_err_data"}, 32'(first_err_data), 32'(fed));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [5:0] ea, input logic [7:0] ed,
                       input logic clr, input logic en, input logic [5:0] pc,
                       input logic [7:0] acc);
    exp_we = we; exp_addr = ea; exp_data = ed; exp_clr = clr;
    chk_en = en; addr = pc; accuValue = acc;
  endtask

  // Called just after a tick, so both reset edges stay clear of the clock.
  task automatic pulse_reset();
    nReset = 1'b0;
    #2;
    nReset = 1'b1;
  endtask

  task automatic add(input logic we, input logic [5:0] ea, input logic [7:0] ed,
                     input logic clr, input logic en, input logic [5:0] pc, input logic [7:0] acc,
                     input logic mm, input logic [15:0] err, input logic [15:0] chk,
                     input logic fl, input logic [5:0] fea, input logic [7:0] fed);
    vec_t v;
    v.we = we; v.ea = ea; v.ed = ed; v.clr = clr; v.en = en; v.pc = pc; v.acc = acc;
    v.mm = mm; v.err = err; v.chk = chk; v.fl = fl; v.fea = fea; v.fed = fed;
    vecs.push_back(v);
  endtask

  initial begin
    logic seen_mm;

    //  we ea ed   clr en pc acc   mm err chk fl fea fed
    add(1, 1, 85,  0, 0, 0, 0,    0, 0, 0,  0, 0, 0);   // program load
    add(1, 2, 80,  0, 0, 0, 0,    0, 0, 0,  0, 0, 0);
    add(1, 3, 240, 0, 0, 0, 0,    0, 0, 0,  0, 0, 0);
    add(1, 4, 255, 0, 0, 0, 0,    0, 0, 0,  0, 0, 0);
    add(1, 5, 0,   0, 0, 0, 0,    0, 0, 0,  0, 0, 0);
    add(0, 0, 0,   0, 1, 0, 0,    0, 0, 0,  0, 0, 0);   // entry 0 invalid
    add(0, 0, 0,   0, 1, 1, 85,   0, 0, 1,  0, 0, 0);   // program pass
    add(0, 0, 0,   0, 1, 2, 80,   0, 0, 2,  0, 0, 0);
    add(0, 0, 0,   0, 1, 3, 240,  0, 0, 3,  0, 0, 0);
    add(0, 0, 0,   0, 1, 4, 255,  0, 0, 4,  0, 0, 0);
    add(0, 0, 0,   0, 1, 5, 0,    0, 0, 5,  0, 0, 0);
    add(0, 0, 0,   0, 1, 6, 0,    0, 0, 5,  0, 0, 0);   // entry 6 invalid
    add(1, 3, 241, 0, 0, 0, 0,    0, 0, 5,  0, 0, 0);   // corrupt entry 3
    add(0, 0, 0,   0, 1, 3, 240,  1, 1, 6,  1, 3, 240); // first failure
    add(0, 0, 0,   0, 1, 4, 255,  0, 1, 7,  1, 3, 240); // pulse drops
    add(1, 2, 81,  0, 0, 0, 0,    0, 1, 7,  1, 3, 240);
    add(1, 4, 0,   0, 0, 0, 0,    0, 1, 7,  1, 3, 240);
    add(0, 0, 0,   0, 1, 2, 80,   1, 2, 8,  1, 3, 240); // first capture held
    add(0, 0, 0,   0, 1, 4, 255,  1, 3, 9,  1, 3, 240);
    add(0, 0, 0,   0, 0, 4, 255,  0, 3, 9,  1, 3, 240); // chk_en gating
    add(0, 0, 0,   1, 0, 0, 0,    0, 3, 9,  1, 3, 240); // clear valid bits
    add(0, 0, 0,   0, 1, 1, 0,    0, 3, 9,  1, 3, 240); // cleared entry ignored
    add(1, 1, 7,   1, 1, 1, 9,    0, 3, 9,  1, 3, 240); // clr+we, compare sees old valid
    add(0, 0, 0,   0, 1, 1, 7,    0, 3, 10, 1, 3, 240); // write won over clear
    add(0, 0, 0,   0, 1, 2, 0,    0, 3, 10, 1, 3, 240); // entry 2 was cleared
    add(1, 1, 9,   0, 1, 1, 7,    0, 3, 11, 1, 3, 240); // same-cycle write: old data used
    add(0, 0, 0,   0, 1, 1, 7,    1, 4, 12, 1, 3, 240); // new data from next cycle

    drive(0, 0, 0, 0, 0, 0, 0);
    nReset = 1'b0;
    #3;
    check_all("in reset", 0, 0, 0, 0, 0, 0);
    #3;
    nReset = 1'b1;

    // Idle: no entries loaded, PC runs 0..63 with checking on.
    seen_mm = 1'b0;
    for (int pc = 0; pc < 64; pc++) begin
      drive(0, 0, 0, 0, 1, 6'(pc), 8'(pc * 3));
      tick();
      seen_mm |= mismatch;
    end
    check("idle chk_count", 32'(chk_count), 0);
    check("idle err_count", 32'(err_count), 0);
    check("idle mismatch seen", 32'(seen_mm), 0);
    check("idle fail", 32'(fail), 0);

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].ea, vecs[i].ed, vecs[i].clr, vecs[i].en, vecs[i].pc, vecs[i].acc);
      tick();
      check_all($sformatf("v%0d", i), vecs[i].mm, vecs[i].err, vecs[i].chk,
                vecs[i].fl, vecs[i].fea, vecs[i].fed);
    end

    // Mid-run reset: outputs clear without a clock edge.
    drive(0, 0, 0, 0, 1, 1, 9);
    tick();
    #2 nReset = 1'b0;
    #1 check_all("async reset", 0, 0, 0, 0, 0, 0);
    #2 nReset = 1'b1;
    tick();
    check_all("after reset valid cleared", 0, 0, 0, 0, 0, 0);

    // Multiple failures from a clean start: first capture stays at PC 2.
    drive(1, 2, 81, 0, 0, 0, 0); tick();
    drive(1, 4, 0,  0, 0, 0, 0); tick();
    drive(0, 0, 0,  0, 1, 2, 80); tick();
    check_all("multi pc2", 1, 1, 1, 1, 2, 80);
    drive(0, 0, 0,  0, 1, 3, 240); tick();
    check_all("multi pc3", 0, 1, 1, 1, 2, 80);
    drive(0, 0, 0,  0, 1, 4, 255); tick();
    check_all("multi pc4", 1, 2, 2, 1, 2, 80);

    // Same-cycle write to a previously invalid entry.
    pulse_reset();
    drive(1, 5, 0, 0, 1, 5, 0); tick();
    check_all("wr+cmp same cycle", 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 5, 0); tick();
    check_all("wr+cmp next visit", 0, 0, 1, 0, 0, 0);

    // Address range boundary on the 40-entry instance.
    pulse_reset();
    drive(1, 39, 5, 0, 0, 0, 0); tick();
    drive(1, 40, 5, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 39, 6); tick();
    check("small pc39 err_count", 32'(s_err_count), 1);
    check("small pc39 mismatch", 32'(s_mismatch), 1);
    check("small pc39 first_err_addr", 32'(s_first_err_addr), 39);
    drive(0, 0, 0, 0, 1, 40, 6); tick();
    check("small pc40 chk_count", 32'(s_chk_count), 1);
    check("small pc40 err_count", 32'(s_err_count), 1);
    check("small pc40 mismatch", 32'(s_mismatch), 0);
    check("small pc40 fail", 32'(s_fail), 1);
    check("big pc40 chk_count", 32'(chk_count), 2);
    check("big pc40 err_count", 32'(err_count), 2);

    // Saturation: every compare fails, so both counters climb together.
    pulse_reset();
    drive(1, 0, 1, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int n = 0; n < 65535; n++) tick();
    check_all("at 0xFFFF", 1, 16'hFFFF, 16'hFFFF, 1, 0, 0);
    tick();
    check_all("saturated", 1, 16'hFFFF, 16'hFFFF, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
